mem_stage: RTL and testbench

- Memory-access stage between the EX/MEM pipeline register and writeback.
- Consumes the registered EX/MEM outputs: ALU result used as address, rd/erd, read/write enables, access width and store data.
- Runs a request/acknowledge handshake to the data memory, aligns store data and byte strobes, extracts and extends load data, and stalls upstream while an access is outstanding.
- Registers the writeback payload: rd, write enable and write data.

---
 rtl/mem_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Sits between the EX/MEM register and writeback. Each load or store is
// checked for alignment, then a single request is issued to the data memory
// and held until it is acknowledged. Store data and byte strobes are moved
// onto the correct byte lanes, and load data is extracted and extended. The
// writeback payload (rd, enable, data) is registered.
module mem_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int RF_SIZE    = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] alures_i,
    input  logic                  erd_i,
    input  logic [RF_SIZE-1:0]    rd_i,
    input  logic                  ememr_i,
    input  logic                  ememw_i,
    input  logic [2:0]            memwid_i,
    input  logic [DATA_WIDTH-1:0] memdata_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [7:0]            dmem_wstrb_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  erd_o,
    output logic [RF_SIZE-1:0]    rd_o,
    output logic [DATA_WIDTH-1:0] wbdata_o,
    output logic                  misalign_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_erd;
    logic [RF_SIZE-1:0]   r_rd;
    logic [2:0]           r_width;
    logic [2:0]           r_off;

    logic                  w_acc;
    logic [2:0]            w_off;
    logic                  w_mis;
    logic [7:0]            w_strb_base;
    logic [7:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rshift;
    logic [DATA_WIDTH-1:0] w_load;

    // Extract and extend load data from a word already shifted down to lane 0.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [2:0]            width,
        input logic [DATA_WIDTH-1:0] sh
    );
        logic [DATA_WIDTH-1:0] res;
        case (width)
            3'b000:  res = {{(DATA_WIDTH-8){sh[7]}},   sh[7:0]};
            3'b001:  res = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b010:  res = {{(DATA_WIDTH-32){sh[31]}}, sh[31:0]};
            3'b011:  res = sh;
            3'b100:  res = {{(DATA_WIDTH-8){1'b0}},    sh[7:0]};
            3'b101:  res = {{(DATA_WIDTH-16){1'b0}},   sh[15:0]};
            3'b110:  res = {{(DATA_WIDTH-32){1'b0}},   sh[31:0]};
            default: res = {DATA_WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    assign w_acc    = ememr_i | ememw_i;
    assign w_off    = alures_i[2:0];
    assign w_wdata  = memdata_i << {w_off, 3'b000};
    assign w_wstrb  = w_strb_base << w_off;
    assign w_rshift = dmem_rdata_i >> {r_off, 3'b000};
    assign w_load   = extend_load(r_width, w_rshift);

    // Alignment check: offset must be a multiple of the access size; code 111 is never legal.
    always_comb begin
        w_mis = 1'b0;
        case (memwid_i)
            3'b001, 3'b101: w_mis = w_off[0];
            3'b010, 3'b110: w_mis = |w_off[1:0];
            3'b011:         w_mis = |w_off;
            3'b111:         w_mis = w_acc;
            default:        w_mis = 1'b0;
        endcase
    end

    // Unshifted strobe pattern for the access size (unsigned codes share the signed sizes).
    always_comb begin
        w_strb_base = 8'h00;
        case (memwid_i[1:0])
            2'b00:   w_strb_base = 8'h01;
            2'b01:   w_strb_base = 8'h03;
            2'b10:   w_strb_base = 8'h0F;
            default: w_strb_base = 8'hFF;
        endcase
    end

    // Upstream hold: raised on the acceptance cycle and while waiting for ack; forced low in reset.
    always_comb begin
        stall_o = 1'b0;
        if (rst_i) begin
            stall_o = 1'b0;
        end else if (r_state == ST_IDLE) begin
            stall_o = w_acc & ~w_mis;
        end else begin
            stall_o = ~dmem_ack_i;
        end
    end

    // Access FSM: issues and holds the memory request, registers writeback payload and fault pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_erd        <= 1'b0;
            r_rd         <= {RF_SIZE{1'b0}};
            r_width      <= 3'b000;
            r_off        <= 3'b000;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= {DATA_WIDTH{1'b0}};
            dmem_wdata_o <= {DATA_WIDTH{1'b0}};
            dmem_wstrb_o <= 8'h00;
            erd_o        <= 1'b0;
            rd_o         <= {RF_SIZE{1'b0}};
            wbdata_o     <= {DATA_WIDTH{1'b0}};
            misalign_o   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    misalign_o <= 1'b0;
                    if (!w_acc) begin
                        erd_o    <= erd_i;
                        rd_o     <= rd_i;
                        wbdata_o <= alures_i;
                    end else if (w_mis) begin
                        erd_o      <= 1'b0;
                        misalign_o <= 1'b1;
                    end else begin
                        r_erd        <= erd_i;
                        r_rd         <= rd_i;
                        r_width      <= memwid_i;
                        r_off        <= w_off;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= ememw_i;
                        dmem_addr_o  <= {alures_i[DATA_WIDTH-1:3], 3'b000};
                        dmem_wdata_o <= w_wdata;
                        dmem_wstrb_o <= ememw_i ? w_wstrb : 8'h00;
                        erd_o        <= 1'b0;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    misalign_o <= 1'b0;
                    if (dmem_ack_i) begin
                        erd_o      <= r_erd;
                        rd_o       <= r_rd;
                        wbdata_o   <= dmem_we_o ? {DATA_WIDTH{1'b0}} : w_load;
                        dmem_req_o <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        erd_o <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    dmem_req_o <= 1'b0;
                    erd_o      <= 1'b0;
                    misalign_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: drives mem_stage as the EX/MEM register and data memory would,
// and compares every cycle against expectations computed from byte-level rules.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] alures_i;
    logic        erd_i;
    logic [4:0]  rd_i;
    logic        ememr_i;
    logic        ememw_i;
    logic [2:0]  memwid_i;
    logic [63:0] memdata_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [63:0] dmem_addr_o;
    logic [63:0] dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_ack_i;
    logic [63:0] dmem_rdata_i;
    logic        erd_o;
    logic [4:0]  rd_o;
    logic [63:0] wbdata_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage #(.DATA_WIDTH(64), .RF_SIZE(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alures_i     (alures_i),
        .erd_i        (erd_i),
        .rd_i         (rd_i),
        .ememr_i      (ememr_i),
        .ememw_i      (ememw_i),
        .memwid_i     (memwid_i),
        .memdata_i    (memdata_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_wstrb_o (dmem_wstrb_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .erd_o        (erd_o),
        .rd_o         (rd_o),
        .wbdata_o     (wbdata_o),
        .misalign_o   (misalign_o)
    );

    // Free-running clock, period 10.
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int acc_bytes(input logic [2:0] wid);
        return 1 << wid[1:0];
    endfunction

    function automatic logic ref_mis(input logic acc, input logic [2:0] wid, input logic [63:0] a);
        int off;
        off = int'(a[2:0]);
        if (!acc) return 1'b0;
        if (wid == 3'd7) return 1'b1;
        return (off % acc_bytes(wid)) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] wid, input logic [63:0] rdata, input logic [63:0] a);
        logic [63:0] v;
        int off, n;
        off = int'(a[2:0]);
        n   = acc_bytes(wid);
        v   = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!wid[2] && n < 8 && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [2:0] wid, input logic [63:0] a);
        logic [7:0] s;
        int off;
        off = int'(a[2:0]);
        s = 8'h00;
        for (int i = 0; i < acc_bytes(wid); i++) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] md, input logic [63:0] a);
        logic [63:0] d;
        int off;
        off = int'(a[2:0]);
        d = 64'd0;
        for (int i = 0; i < 8 - off; i++) d[8*(off+i) +: 8] = md[8*i +: 8];
        return d;
    endfunction

    // Present one instruction at a negedge and follow it to writeback, checking every cycle.
    // Returns at a negedge.
    task automatic run_op(input logic [4:0] rd, input logic erd, input logic [63:0] a,
                          input logic r, input logic w, input logic [2:0] wid,
                          input logic [63:0] md, input int dly, input logic [63:0] rdata,
                          input logic idle_ack);
        logic acc, mis;
        logic [63:0] exp_wb;
        acc = r | w;
        mis = ref_mis(acc, wid, a);
        alures_i = a; rd_i = rd; erd_i = erd; ememr_i = r; ememw_i = w;
        memwid_i = wid; memdata_i = md;
        dmem_ack_i = idle_ack;
        dmem_rdata_i = {$urandom, $urandom};
        #1;
        if (!acc || mis) begin
            check_val("stall_idle", {63'd0, stall_o}, 64'd0);
            @(posedge clk_i); @(negedge clk_i);
            check_val("req_idle", {63'd0, dmem_req_o}, 64'd0);
            check_val("misalign", {63'd0, misalign_o}, {63'd0, mis});
            check_val("erd_idle", {63'd0, erd_o}, {63'd0, (!acc) & erd});
            if (!acc) begin
                check_val("rd_alu", {59'd0, rd_o}, {59'd0, rd});
                check_val("wb_alu", wbdata_o, a);
            end
        end else begin
            dmem_ack_i = 1'b0;
            #1;
            check_val("stall_accept", {63'd0, stall_o}, 64'd1);
            @(posedge clk_i); @(negedge clk_i);
            check_val("req_issue", {63'd0, dmem_req_o}, 64'd1);
            check_val("we", {63'd0, dmem_we_o}, {63'd0, w});
            check_val("addr", dmem_addr_o, {a[63:3], 3'b000});
            check_val("wstrb", {56'd0, dmem_wstrb_o}, {56'd0, (w ? ref_strb(wid, a) : 8'h00)});
            if (w) check_val("wdata", dmem_wdata_o, ref_wdata(md, a));
            check_val("erd_bubble", {63'd0, erd_o}, 64'd0);
            check_val("misalign_acc", {63'd0, misalign_o}, 64'd0);
            for (int i = 0; i < dly; i++) begin
                #1;
                check_val("stall_wait", {63'd0, stall_o}, 64'd1);
                @(posedge clk_i); @(negedge clk_i);
                check_val("req_held", {63'd0, dmem_req_o}, 64'd1);
                check_val("addr_held", dmem_addr_o, {a[63:3], 3'b000});
                check_val("erd_wait", {63'd0, erd_o}, 64'd0);
                dmem_rdata_i = {$urandom, $urandom};
            end
            dmem_ack_i   = 1'b1;
            dmem_rdata_i = rdata;
            #1;
            check_val("stall_ack", {63'd0, stall_o}, 64'd0);
            @(posedge clk_i);
            #1 dmem_ack_i = 1'b0;
            @(negedge clk_i);
            exp_wb = w ? 64'd0 : ref_load(wid, rdata, a);
            check_val("req_drop", {63'd0, dmem_req_o}, 64'd0);
            check_val("erd_wb", {63'd0, erd_o}, {63'd0, erd});
            check_val("rd_wb", {59'd0, rd_o}, {59'd0, rd});
            check_val("wb_data", wbdata_o, exp_wb);
        end
    endtask

    // Bound on total run time.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        logic [63:0] a, md, rdata;
        logic [2:0]  wid;
        int          kind;
        rst_i = 1'b1; alures_i = 64'd0; erd_i = 1'b0; rd_i = 5'd0; ememr_i = 1'b0;
        ememw_i = 1'b0; memwid_i = 3'd0; memdata_i = 64'd0; dmem_ack_i = 1'b0;
        dmem_rdata_i = 64'd0;
        #12;
        check_val("rst_req", {63'd0, dmem_req_o}, 64'd0);
        check_val("rst_erd", {63'd0, erd_o}, 64'd0);
        check_val("rst_wb", wbdata_o, 64'd0);
        check_val("rst_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Directed cases.
        run_op(5'd5, 1'b1, 64'h1234, 1'b0, 1'b0, 3'b000, 64'd0, 0, 64'd0, 1'b0);
        run_op(5'd7, 1'b1, 64'h1003, 1'b1, 1'b0, 3'b000, 64'd0, 0, 64'h00000000_80000000, 1'b0);
        check_val("lb_value", wbdata_o, 64'hFFFFFFFF_FFFFFF80);
        run_op(5'd7, 1'b1, 64'h1003, 1'b1, 1'b0, 3'b100, 64'd0, 0, 64'h00000000_80000000, 1'b0);
        check_val("lbu_value", wbdata_o, 64'h80);
        run_op(5'd0, 1'b0, 64'h2004, 1'b0, 1'b1, 3'b010, 64'hDEADBEEF, 3, 64'd0, 1'b0);
        run_op(5'd9, 1'b1, 64'h2002, 1'b1, 1'b0, 3'b011, 64'd0, 0, 64'd0, 1'b0);
        run_op(5'd9, 1'b1, 64'h2000, 1'b1, 1'b0, 3'b111, 64'd0, 0, 64'd0, 1'b0);
        check_val("mis_pulse_end", {63'd0, misalign_o}, 64'd1);
        run_op(5'd3, 1'b1, 64'h3008, 1'b1, 1'b0, 3'b011, 64'd0, 0, 64'h01234567_89ABCDEF, 1'b0);
        check_val("mis_cleared", {63'd0, misalign_o}, 64'd0);
        run_op(5'd4, 1'b1, 64'h3006, 1'b1, 1'b0, 3'b001, 64'd0, 1, 64'h8001_0000_0000_0000, 1'b0);
        check_val("lh_value", wbdata_o, 64'hFFFFFFFF_FFFF8001);
        run_op(5'd6, 1'b1, 64'h0, 1'b0, 1'b0, 3'b000, 64'd0, 0, 64'd0, 1'b1);

        // Reset in the middle of WAIT: outputs clear before any clock edge.
        alures_i = 64'h4000; rd_i = 5'd11; erd_i = 1'b1; ememr_i = 1'b1; ememw_i = 1'b0;
        memwid_i = 3'b011; dmem_ack_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check_val("pre_rst_req", {63'd0, dmem_req_o}, 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check_val("rst_mid_req", {63'd0, dmem_req_o}, 64'd0);
        check_val("rst_mid_addr", dmem_addr_o, 64'd0);
        check_val("rst_mid_stall", {63'd0, stall_o}, 64'd0);
        check_val("rst_mid_erd", {63'd0, erd_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_op(5'd12, 1'b1, 64'h4010, 1'b1, 1'b0, 3'b110, 64'd0, 2, 64'hFFFF_FFFF_8765_4321, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            wid  = 3'($urandom_range(0, 7));
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'(a[2:0] & ~((acc_bytes(wid) - 1) & 7));
            md    = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            run_op(5'($urandom), (kind == 2) ? 1'b0 : 1'($urandom), a, kind == 1, kind == 2,
                   wid, md, $urandom_range(0, 3), rdata, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
